// File: rtl/sine_dac_pkg.sv
// rtl/sine_dac_pkg.sv - shared constants and helpers for the sine PWM DAC output stage
//
// Contents:
//   DAC_WIDTH    default sample / PWM counter width
//   DAC_MIDSCALE mid-scale code for DAC_WIDTH (offset-binary zero)
//   DAC_MAX      last counter value of a PWM period for DAC_WIDTH
//   midscale(w)  mid-scale code for an arbitrary width
//   max_code(w)  all-ones code for an arbitrary width
package sine_dac_pkg;

    function automatic int midscale(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int max_code(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int DAC_WIDTH    = 8;
    localparam int DAC_MIDSCALE = midscale(DAC_WIDTH);
    localparam int DAC_MAX      = max_code(DAC_WIDTH);

endpackage

// File: rtl/sine_pwm_dac_tick_gen.sv
// rtl/sine_pwm_dac_tick_gen.sv - PWM tick prescaler (module pwm_tick_gen)
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset; clears the prescaler to 0
//   tick   out  high for one clk cycle every PRESCALE cycles (when the
//                prescaler sits at PRESCALE-1); constantly high for PRESCALE=1
module pwm_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (pcnt == LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick = (pcnt == LAST);

endmodule

// File: rtl/sine_pwm_dac.sv
// rtl/sine_pwm_dac.sv - sample-to-PWM output stage fed by the sine lookup table
//
// Optional feature: define PWM_DAC_PRESCALE_EN to divide the PWM tick by
// PRESCALE through pwm_tick_gen; otherwise the counter ticks every clk.
//
// Ports:
//   clk           in   clock
//   reset         in   synchronous, active-high reset
//   sample_in     in   WIDTH-bit offset-binary sample
//   sample_valid  in   sample_in valid this cycle
//   sample_req    out  one-cycle strobe after each period boundary
//   pwm_out       out  registered PWM pin (cnt < duty)
//   duty          out  duty value currently in force
//   underrun      out  sticky: boundary reached with nothing pending
//   overrun       out  sticky: pending sample overwritten before use
module sine_pwm_dac
    import sine_dac_pkg::*;
#(
    parameter int WIDTH    = DAC_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_req,
    output logic             pwm_out,
    output logic [WIDTH-1:0] duty,
    output logic             underrun,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] MIDSCALE = WIDTH'(midscale(WIDTH));
    localparam logic [WIDTH-1:0] MAX      = WIDTH'(max_code(WIDTH));

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("sine_pwm_dac: PRESCALE must be at least 1");
    end

    logic             tick;
    logic             boundary;
    logic             consume;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hold;
    logic             pending;

`ifdef PWM_DAC_PRESCALE_EN
    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign boundary = tick && (cnt == MAX);
    // The boundary takes the pending sample in the same edge a new one may
    // arrive, so a simultaneous write is not an overwrite.
    assign consume  = boundary && pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            duty       <= MIDSCALE;
            hold       <= '0;
            pending    <= 1'b0;
            pwm_out    <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= cnt + 1'b1;
            end

            sample_req <= boundary;
            pwm_out    <= (cnt < duty);

            if (boundary) begin
                if (pending) begin
                    duty <= hold;
                end else begin
                    underrun <= 1'b1;
                end
            end

            // A sample arriving on an empty boundary only becomes pending;
            // it is never bypassed straight into duty.
            if (sample_valid) begin
                hold    <= sample_in;
                pending <= 1'b1;
                if (pending && !consume) begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sine_pwm_dac.sv
// tb/tb_sine_pwm_dac.sv - randomized self-checking bench for sine_pwm_dac
module tb_sine_pwm_dac;

`ifdef PWM_DAC_PRESCALE_EN
    localparam int PRESC = 4;
`else
    localparam int PRESC = 1;
`endif
    localparam int PER = 256 * PRESC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sample_in = 8'h00;
    logic       sample_valid = 1'b0;
    logic       sample_req;
    logic       pwm_out;
    logic [7:0] duty;
    logic       underrun;
    logic       overrun;

    always #5 clk = ~clk;

    sine_pwm_dac #(
        .WIDTH    (8),
        .PRESCALE (PRESC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_req   (sample_req),
        .pwm_out      (pwm_out),
        .duty         (duty),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the period is derived from the number of
    // clk edges since reset, not from a mirrored counter.
    int         mk;
    logic [7:0] m_duty, m_hold;
    bit         m_pend, m_under, m_over, m_req, m_pwm;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin : model
        int pos;
        bit bnd, used;
        if (reset) begin
            mk = 0; m_duty = 8'h80; m_hold = 8'h00; m_pend = 0;
            m_under = 0; m_over = 0; m_req = 0; m_pwm = 0;
        end else begin
            pos   = (mk / PRESC) % 256;
            bnd   = ((mk % PRESC) == PRESC - 1) && (pos == 255);
            m_pwm = (pos < int'(m_duty));
            m_req = bnd;
            used  = bnd && m_pend;
            if (bnd) begin
                if (m_pend) m_duty = m_hold;
                else        m_under = 1;
            end
            if (sample_valid) begin
                if (m_pend && !used) m_over = 1;
                m_hold = sample_in;
                m_pend = 1;
            end else if (used) begin
                m_pend = 0;
            end
            mk++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pwm_out",    pwm_out,    m_pwm);
            check("model_duty",       duty,       m_duty);
            check("model_sample_req", sample_req, m_req);
            check("model_underrun",   underrun,   m_under);
            check("model_overrun",    overrun,    m_over);
        end
    end

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        sample_valid = 1'b0;
        edge1;
        edge1;
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) edge1;
    endtask

    task automatic send(input logic [7:0] v);
        sample_in = v;
        sample_valid = 1'b1;
        edge1;
        sample_valid = 1'b0;
    endtask

    task automatic to_boundary;
        bit hit = 0;
        for (int i = 0; i < PER + 8 && !hit; i++) begin
            edge1;
            if (mk % PER == 0) hit = 1;
        end
        check("boundary_reached", hit, 1);
    endtask

    task automatic period(input bit en, input logic [7:0] v, input int at, output int highs);
        highs = 0;
        for (int i = 0; i < PER; i++) begin
            if (en && i == at) begin
                sample_in = v;
                sample_valid = 1'b1;
            end
            edge1;
            sample_valid = 1'b0;
            highs += int'(pwm_out);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_duty"},       duty,       8'h80);
        check({tag, "_pwm_out"},    pwm_out,    0);
        check({tag, "_sample_req"}, sample_req, 0);
        check({tag, "_underrun"},   underrun,   0);
        check({tag, "_overrun"},    overrun,    0);
    endtask

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int h;
        int thr;
        int cut;

        do_reset;
        chk_en = 1'b1;

        // Idle: mid-scale duty, underrun at first boundary, strobe right after.
        check_reset_state("reset");
        run(PER - 1);
        check("idle_req_before", sample_req, 0);
        check("idle_under_before", underrun, 0);
        edge1;
        check("idle_req_pulse", sample_req, 1);
        check("idle_underrun", underrun, 1);
        edge1;
        check("idle_req_width", sample_req, 0);
        do_reset;
        period(0, 8'h00, 0, h);
        check("idle_high_count", h, 128 * PRESC);
        check("idle_req_period", sample_req, 1);

        // Single sample mid-period.
        do_reset;
        run(100 * PRESC);
        send(8'h40);
        to_boundary;
        check("s40_duty", duty, 8'h40);
        check("s40_underrun", underrun, 0);
        period(0, 8'h00, 0, h);
        check("s40_high_count", h, 64 * PRESC);
        check("s40_overrun", overrun, 0);

        // Extremes: all low, then high on all but one tick.
        do_reset;
        send(8'h00);
        to_boundary;
        period(1, 8'hFF, 10, h);
        check("s00_high_count", h, 0);
        check("sff_duty", duty, 8'hFF);
        period(0, 8'h00, 0, h);
        check("sff_high_count", h, 255 * PRESC);

        // Two samples in one period.
        do_reset;
        send(8'h10);
        send(8'h20);
        check("double_overrun", overrun, 1);
        to_boundary;
        check("double_duty", duty, 8'h20);

        // New sample exactly on the boundary while one is pending.
        do_reset;
        send(8'h30);
        run(PER - 2);
        send(8'h50);
        check("coincide_duty_now", duty, 8'h30);
        check("coincide_overrun", overrun, 0);
        check("coincide_underrun", underrun, 0);
        to_boundary;
        check("coincide_duty_next", duty, 8'h50);
        check("coincide_underrun2", underrun, 0);
        check("coincide_overrun2", overrun, 0);

        // Randomized traffic, density rising across periods.
        do_reset;
        for (int i = 0; i < 6 * PER; i++) begin
            thr = 1 + 2 * (i / PER);
            sample_valid = ($urandom_range(0, 199) < thr);
            sample_in = 8'($urandom);
            edge1;
        end
        sample_valid = 1'b0;

        // Reset in the middle of a period with a sample pending.
        cut = $urandom_range(10, PER - 10);
        run(cut);
        send(8'hC3);
        do_reset;
        check_reset_state("midreset");
        period(0, 8'h00, 0, h);
        check("midreset_high_count", h, 128 * PRESC);
        check("midreset_req", sample_req, 1);
        check("midreset_duty", duty, 8'h80);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
